mersenne_batch_scheduler: RTL and testbench
===========================================

MERSENNE_BATCH_SCHEDULER -- requirements
Module: mersenne_batch_scheduler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: job queue entries (power of two).
REQ-002 SHALL have parameter TIMEOUT, default 4096: max WAIT cycles before abandoning a job.
REQ-003 SHALL have parameter MAX_EXP, default 31: largest accepted exponent; minimum accepted is 2.
REQ-004 SHALL use one clock and a synchronous, active-low reset.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- job_valid  in  1  job offered
- job_exponent  in  8  exponent p of M_p
- job_ready  out  1  queue can accept job
- t_start  out  1  one-cycle start pulse to tester
- t_exponent  out  8  exponent to tester
- t_done  in  1  tester completion
- t_is_prime  in  1  tester verdict
- t_cycles  in  16  tester cycle count
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res_exponent  out  8  exponent of reported job
- res_is_prime  out  1  verdict, 0 unless status OK
- res_cycles  out  16  tester cycles, 0 unless status OK
- res_status  out  2  00 OK, 01 BAD_EXP, 10 TIMEOUT
- busy  out  1  state not IDLE or queue non-empty
- jobs_done  out  16  results handed off, wraps
- primes_found  out  16  OK results with is_prime=1, wraps
- total_cycles  out  32  sum of OK res_cycles, saturates at 0xFFFFFFFF

Function
REQ-005 SHALL push job when job_valid && job_ready; job_ready = queue not full; push refused when full even if pop occurs same cycle.
REQ-006 SHALL run FSM IDLE, LAUNCH, WAIT, EMIT.
REQ-007 IDLE: if queue non-empty, pop head into exp_reg; exponent outside 2..MAX_EXP -> EMIT with BAD_EXP, no t_start; else -> LAUNCH.
REQ-008 LAUNCH: t_start=1 for exactly one cycle; -> WAIT; t_exponent = exp_reg from LAUNCH through WAIT, else 0.
REQ-009 Job pushed into empty queue in cycle N (scheduler IDLE) SHALL yield t_start=1 in cycle N+2.
REQ-010 WAIT SHALL ignore t_done in its first cycle (stale level from previous job); on first later cycle with t_done=1 capture t_is_prime, t_cycles, status OK -> EMIT.
REQ-011 WAIT SHALL count cycles; at TIMEOUT cycles without accepted t_done -> EMIT with TIMEOUT.
REQ-012 EMIT: res_valid=1, all res_* stable until res_ready; on handshake update counters in same edge, -> IDLE.
REQ-013 No new t_start while res_valid=1 (result backpressure stalls the tester).
REQ-014 t_done, t_is_prime, t_cycles SHALL be ignored outside WAIT.

Reset
REQ-015 rst_n=0 on a clock edge SHALL force IDLE, empty queue, all counters 0, t_start=0, t_exponent=0, res_valid=0, res_* =0, busy=0, job_ready=0 during reset then 1.
REQ-016 Reset mid-WAIT or mid-EMIT SHALL discard in-flight job and queue contents without emitting a result.

Structure
REQ-017 Shared package mersenne_pkg SHALL hold FSM state encoding, status codes (OK, BAD_EXP, TIMEOUT), default FIFO_DEPTH/TIMEOUT/MAX_EXP.
REQ-018 Job queue SHALL be sub-module mersenne_job_fifo (synchronous, 8-bit, full/empty flags); FSM and counters in top.

Verification
REQ-019 Push 13; tester model asserts t_done after 20 cycles with is_prime=1, cycles=20 -> t_start at N+2, t_exponent=13, result {13,1,20,00}; jobs_done=1, primes_found=1, total_cycles=20.
REQ-020 Push 1 then 40 -> two results status 01, is_prime=0, cycles=0, no t_start; jobs_done=2, total_cycles=0.
REQ-021 Tester stalled, push 17,19,31,13,7 back-to-back -> job_ready low once queue full, blocked job retained by source; results in order 17,19,31,13,7.
REQ-022 Tester never asserts t_done for job 19 -> result status 10 exactly TIMEOUT cycles into WAIT; next job launches after handshake.
REQ-023 res_ready held low 10 cycles with queued jobs -> res_* stable, no t_start until handshake.
REQ-024 rst_n low one edge during WAIT with 3 queued jobs -> all outputs reset values, no result emitted, busy=0.

Source files
------------

// File: rtl/mersenne_pkg.sv
// mersenne_pkg: FSM encoding, result status codes and default parameters shared by the scheduler
package mersenne_pkg;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT = 4096;
    localparam int DEF_MAX_EXP = 31;
    localparam int MIN_EXP = 2;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_EMIT} state_t;
    typedef enum logic [1:0] {ST_OK = 2'b00, ST_BAD_EXP = 2'b01, ST_TIMEOUT = 2'b10} status_t;
    function automatic logic exp_ok(input logic [7:0] p, input int max_exp);
        return int'(p) >= MIN_EXP && int'(p) <= max_exp;
    endfunction
endpackage

// File: rtl/mersenne_job_fifo.sv
// mersenne_job_fifo: synchronous queue of 8-bit exponents with full/empty flags
module mersenne_job_fifo
    import mersenne_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout = mem[rd_ptr[AW-1:0]];
    // storage write, no reset needed since pointers gate visibility
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
    // pointer update; a push into a full queue is refused even when a pop happens in the same cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/mersenne_batch_scheduler.sv
// mersenne_batch_scheduler: queues exponents, dispatches them to a primality tester and reports results with statistics
module mersenne_batch_scheduler
    import mersenne_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int MAX_EXP = DEF_MAX_EXP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    input  logic [7:0]  job_exponent,
    output logic        job_ready,
    output logic        t_start,
    output logic [7:0]  t_exponent,
    input  logic        t_done,
    input  logic        t_is_prime,
    input  logic [15:0] t_cycles,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_exponent,
    output logic        res_is_prime,
    output logic [15:0] res_cycles,
    output logic [1:0]  res_status,
    output logic        busy,
    output logic [15:0] jobs_done,
    output logic [15:0] primes_found,
    output logic [31:0] total_cycles
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state;
    logic [7:0] exp_reg;
    logic [CW-1:0] wait_cnt;
    logic [7:0] head;
    logic full;
    logic empty;
    logic pop;
    logic [32:0] cyc_sum;
    assign job_ready = rst_n && !full;
    assign pop = state == S_IDLE && !empty;
    assign busy = state != S_IDLE || !empty;
    assign cyc_sum = {1'b0, total_cycles} + {17'b0, res_cycles};

    mersenne_job_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (job_valid && job_ready),
        .din   (job_exponent),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // job sequencing with registered tester/result outputs and handshake-time statistics
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            exp_reg      <= '0;
            wait_cnt     <= '0;
            t_start      <= 1'b0;
            t_exponent   <= '0;
            res_valid    <= 1'b0;
            res_exponent <= '0;
            res_is_prime <= 1'b0;
            res_cycles   <= '0;
            res_status   <= ST_OK;
            jobs_done    <= '0;
            primes_found <= '0;
            total_cycles <= '0;
        end else begin
            t_start <= 1'b0;
            case (state)
                S_IDLE: if (!empty) begin
                    exp_reg <= head;
                    if (exp_ok(head, MAX_EXP)) begin
                        state      <= S_LAUNCH;
                        t_start    <= 1'b1;
                        t_exponent <= head;
                    end else begin
                        state        <= S_EMIT;
                        res_valid    <= 1'b1;
                        res_exponent <= head;
                        res_status   <= ST_BAD_EXP;
                    end
                end
                S_LAUNCH: begin
                    state    <= S_WAIT;
                    wait_cnt <= '0;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // the first WAIT cycle may still see the previous job's done level
                    if (wait_cnt != '0 && t_done) begin
                        state        <= S_EMIT;
                        t_exponent   <= '0;
                        res_valid    <= 1'b1;
                        res_exponent <= exp_reg;
                        res_is_prime <= t_is_prime;
                        res_cycles   <= t_cycles;
                        res_status   <= ST_OK;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        state        <= S_EMIT;
                        t_exponent   <= '0;
                        res_valid    <= 1'b1;
                        res_exponent <= exp_reg;
                        res_status   <= ST_TIMEOUT;
                    end
                end
                S_EMIT: if (res_ready) begin
                    state        <= S_IDLE;
                    jobs_done    <= jobs_done + 1'b1;
                    primes_found <= primes_found + 16'(res_status == ST_OK && res_is_prime);
                    total_cycles <= cyc_sum[32] ? '1 : cyc_sum[31:0];
                    res_valid    <= 1'b0;
                    res_exponent <= '0;
                    res_is_prime <= 1'b0;
                    res_cycles   <= '0;
                    res_status   <= ST_OK;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mersenne_batch_scheduler.sv
// tb_mersenne_batch_scheduler: table vectors, directed corner sequences and random traffic against a job-level model
module tb_mersenne_batch_scheduler;
    localparam int TO = 64;
    localparam int MAXE = 31;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        job_valid = 1'b0;
    logic [7:0]  job_exponent = '0;
    logic        job_ready;
    logic        t_start;
    logic [7:0]  t_exponent;
    logic        t_done = 1'b0;
    logic        t_is_prime = 1'b0;
    logic [15:0] t_cycles = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_exponent;
    logic        res_is_prime;
    logic [15:0] res_cycles;
    logic [1:0]  res_status;
    logic        busy;
    logic [15:0] jobs_done;
    logic [15:0] primes_found;
    logic [31:0] total_cycles;

    always #5 clk = ~clk;

    mersenne_batch_scheduler #(.FIFO_DEPTH(4), .TIMEOUT(TO), .MAX_EXP(MAXE)) dut (
        .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_exponent(job_exponent), .job_ready(job_ready),
        .t_start(t_start), .t_exponent(t_exponent), .t_done(t_done), .t_is_prime(t_is_prime), .t_cycles(t_cycles),
        .res_valid(res_valid), .res_ready(res_ready), .res_exponent(res_exponent), .res_is_prime(res_is_prime),
        .res_cycles(res_cycles), .res_status(res_status), .busy(busy), .jobs_done(jobs_done),
        .primes_found(primes_found), .total_cycles(total_cycles)
    );

    typedef struct { logic [7:0] e; int s; } launch_t;
    typedef struct { logic [7:0] e; bit hang; logic [1:0] st; logic p; logic [15:0] c; } vec_t;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [7:0] push_q[$];
    launch_t lq[$];
    logic [7:0] res_log[$];
    bit resp_hang [256];
    logic [15:0] m_jobs = '0;
    logic [15:0] m_primes = '0;
    logic [31:0] m_total = '0;
    bit mon_en = 0;
    bit have_exp = 0;
    bit ctr_chk = 0;
    logic [7:0] h_e;
    logic h_p;
    logic [15:0] h_c;
    logic [1:0] h_s;
    bit t_active = 0;
    logic [7:0] t_e;
    int t_due = -1;
    int drop_at = -1;
    int garb_at = -1;
    int last_start_cyc = -1;
    int start_count = 0;

    function automatic bit is_mp(input logic [7:0] p);
        return p inside {8'd2, 8'd3, 8'd5, 8'd7, 8'd13, 8'd17, 8'd19, 8'd31};
    endfunction
    function automatic bit valid_exp(input logic [7:0] p);
        return p >= 8'd2 && int'(p) <= MAXE;
    endfunction
    function automatic int delay_of(input logic [7:0] p);
        return int'(p) + 7;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // job-level scoreboard evaluated on the settled outputs of the current cycle
    task automatic monitor();
        logic [7:0] p;
        launch_t l;
        longint sum;
        if (ctr_chk) begin
            check("jobs_done", jobs_done, m_jobs);
            check("primes_found", primes_found, m_primes);
            check("total_cycles", total_cycles, m_total);
            ctr_chk = 0;
        end
        check("busy", busy, push_q.size() != 0);
        if (t_start) begin
            check("t_start_while_res_valid", res_valid, 0);
            start_count++;
            last_start_cyc = cyc;
            lq.push_back('{t_exponent, cyc});
            drop_at = cyc + 2;
            t_active = !resp_hang[t_exponent];
            t_e = t_exponent;
            t_due = cyc + delay_of(t_exponent);
        end
        if (res_valid && !have_exp) begin
            if (push_q.size() == 0) check("res_unexpected", res_valid, 0);
            else begin
                p = push_q[0];
                if (!valid_exp(p)) {h_e, h_p, h_c, h_s} = {p, 1'b0, 16'd0, 2'd1};
                else if (lq.size() == 0) check("launch_missing", lq.size(), 1);
                else begin
                    l = lq[0];
                    check("launch_order", l.e, p);
                    if (resp_hang[p]) begin
                        {h_e, h_p, h_c, h_s} = {p, 1'b0, 16'd0, 2'd2};
                        check("timeout_latency", cyc, l.s + 1 + TO);
                    end else begin
                        {h_e, h_p, h_c, h_s} = {p, is_mp(p), 16'(delay_of(p)), 2'd0};
                        check("done_latency", cyc, l.s + delay_of(p) + 1);
                    end
                end
                check("t_exponent_in_emit", t_exponent, 0);
                res_log.push_back(res_exponent);
                have_exp = 1;
            end
        end
        if (have_exp) begin
            if (!res_valid) begin
                check("res_valid_dropped", res_valid, 1);
                have_exp = 0;
            end else begin
                check("res_fields", {res_exponent, res_is_prime, res_cycles, res_status}, {h_e, h_p, h_c, h_s});
                if (res_ready) begin
                    m_jobs = m_jobs + 16'd1;
                    if (h_s == 2'd0 && h_p) m_primes = m_primes + 16'd1;
                    sum = longint'(m_total) + longint'(h_c);
                    m_total = sum > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : 32'(sum);
                    if (valid_exp(push_q[0])) void'(lq.pop_front());
                    void'(push_q.pop_front());
                    have_exp = 0;
                    ctr_chk = 1;
                end
            end
        end
    endtask

    // tester behaviour: answer after delay_of(p) cycles, then leave a stale done level with garbage data
    task automatic tester();
        if (t_active && cyc == t_due) begin
            t_done = 1'b1;
            t_is_prime = is_mp(t_e);
            t_cycles = 16'(delay_of(t_e));
            t_active = 0;
            garb_at = cyc + 1;
        end else if (cyc == garb_at) begin
            t_is_prime = 1'($urandom);
            t_cycles = 16'($urandom);
        end
        if (cyc == drop_at) t_done = 1'b0;
    endtask

    task automatic model_reset();
        push_q.delete();
        lq.delete();
        have_exp = 0;
        ctr_chk = 0;
        m_jobs = '0;
        m_primes = '0;
        m_total = '0;
        t_active = 0;
        t_done = 1'b0;
        drop_at = -1;
        garb_at = -1;
    endtask

    task automatic step();
        if (mon_en && rst_n) monitor();
        if (job_valid && job_ready) push_q.push_back(job_exponent);
        @(posedge clk);
        #1;
        cyc++;
        if (!rst_n) model_reset();
        else tester();
    endtask

    task automatic push(input logic [7:0] e, output int acc_cyc);
        bit ok;
        ok = 0;
        acc_cyc = -1;
        job_valid = 1'b1;
        job_exponent = e;
        for (int k = 0; k < 400 && !ok; k++) begin
            ok = job_ready;
            acc_cyc = cyc;
            step();
        end
        check("push_accepted", ok, 1);
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input int limit);
        for (int k = 0; k < limit && !res_valid; k++) step();
        check("res_valid_wait", res_valid, 1);
    endtask

    task automatic drain(input int limit);
        for (int k = 0; k < limit && busy; k++) step();
        check("drain_busy", busy, 0);
        check("drain_model_empty", push_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [7:0] order[6];
        logic [7:0] seq5[5];
        int acc;
        int sc0;
        bit acc_now;
        int r;
        tbl[0] = '{8'd13, 0, 2'd0, 1'b1, 16'd20};
        tbl[1] = '{8'd1, 0, 2'd1, 1'b0, 16'd0};
        tbl[2] = '{8'd40, 0, 2'd1, 1'b0, 16'd0};
        tbl[3] = '{8'd2, 0, 2'd0, 1'b1, 16'd9};
        tbl[4] = '{8'd11, 0, 2'd0, 1'b0, 16'd18};
        tbl[5] = '{8'd31, 0, 2'd0, 1'b1, 16'd38};
        tbl[6] = '{8'd32, 0, 2'd1, 1'b0, 16'd0};
        tbl[7] = '{8'd0, 0, 2'd1, 1'b0, 16'd0};
        tbl[8] = '{8'd255, 0, 2'd1, 1'b0, 16'd0};
        tbl[9] = '{8'd19, 1, 2'd2, 1'b0, 16'd0};
        order = '{8'd17, 8'd19, 8'd31, 8'd13, 8'd7, 8'd5};
        seq5 = '{8'd17, 8'd19, 8'd31, 8'd13, 8'd7};

        repeat (3) step();
        check("job_ready_in_reset", job_ready, 0);
        rst_n = 1'b1;
        mon_en = 1;
        check("rst_res_valid", res_valid, 0);
        check("rst_t_start", t_start, 0);
        check("rst_t_exponent", t_exponent, 0);
        check("rst_busy", busy, 0);
        check("rst_res_fields", {res_exponent, res_is_prime, res_cycles, res_status}, 0);
        check("rst_counters", {jobs_done, primes_found} | total_cycles, 0);
        step();
        check("job_ready_after_reset", job_ready, 1);

        // one job at a time from an idle, empty scheduler
        foreach (tbl[i]) begin
            res_ready = 1'b0;
            resp_hang[tbl[i].e] = tbl[i].hang;
            sc0 = start_count;
            push(tbl[i].e, acc);
            wait_res(TO + 50);
            check("tbl_res", {res_exponent, res_is_prime, res_cycles, res_status},
                  {tbl[i].e, tbl[i].p, tbl[i].c, tbl[i].st});
            if (tbl[i].st == 2'd1) check("tbl_bad_no_start", start_count, sc0);
            else check("tbl_start_latency", last_start_cyc, acc + 2);
            res_ready = 1'b1;
            step();
            resp_hang[tbl[i].e] = 0;
        end
        step();
        check("tbl_jobs_done", jobs_done, 10);
        check("tbl_primes_found", primes_found, 3);
        check("tbl_total_cycles", total_cycles, 85);

        // back-to-back jobs with results held off: queue fills, blocked job waits, order preserved
        res_log.delete();
        res_ready = 1'b0;
        foreach (seq5[i]) push(seq5[i], acc);
        job_valid = 1'b1;
        job_exponent = 8'd5;
        wait_res(100);
        sc0 = start_count;
        for (int k = 0; k < 10; k++) begin
            check("job_ready_full", job_ready, 0);
            step();
        end
        check("no_start_while_stalled", start_count, sc0);
        res_ready = 1'b1;
        push(8'd5, acc);
        drain(3000);
        check("order_count", res_log.size(), 6);
        foreach (order[i]) check("order", res_log.size() > i ? res_log[i] : 8'hxx, order[i]);

        // tester never answers job 19
        resp_hang[19] = 1;
        sc0 = start_count;
        push(8'd19, acc);
        push(8'd7, acc);
        drain(3000);
        check("timeout_then_next_start", start_count, sc0 + 2);
        resp_hang[19] = 0;

        // reset in the middle of WAIT with three queued jobs
        push(8'd13, acc);
        push(8'd3, acc);
        push(8'd5, acc);
        push(8'd7, acc);
        repeat (4) step();
        rst_n = 1'b0;
        step();
        check("mid_rst_job_ready", job_ready, 0);
        check("mid_rst_res_valid", res_valid, 0);
        check("mid_rst_t_start", t_start, 0);
        check("mid_rst_t_exponent", t_exponent, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_counters", {jobs_done, primes_found} | total_cycles, 0);
        rst_n = 1'b1;
        sc0 = start_count;
        repeat (40) step();
        check("post_rst_no_start", start_count, sc0);
        check("post_rst_job_ready", job_ready, 1);

        // random traffic with random result backpressure and a never-answered exponent
        resp_hang[23] = 1;
        res_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            acc_now = job_valid && job_ready;
            step();
            if (!job_valid || acc_now) begin
                job_valid = $urandom_range(0, 2) == 0;
                r = int'($urandom_range(0, 9));
                job_exponent = r == 0 ? 8'($urandom) : 8'($urandom_range(0, 40));
            end
            res_ready = $urandom_range(0, 3) != 0;
        end
        job_valid = 1'b0;
        res_ready = 1'b1;
        drain(5000);
        step();
        resp_hang[23] = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
